// File: rtl/tug_referee.sv
// Tug-of-war referee: detects round wins from the end lights and press
// pulses, keeps both scores, freezes play for a hold window, then pulses
// playAgain to re-centre the light chain. Latches game-over at MAX_SCORE.
module tug_referee #(
  parameter int SCORE_W     = 3,
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               L,
  input  logic               R,
  input  logic               leftEnd,
  input  logic               rightEnd,
  output logic               playAgain,
  output logic [SCORE_W-1:0] leftScore,
  output logic [SCORE_W-1:0] rightScore,
  output logic [1:0]         winner,
  output logic               gameOver
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RESTART = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;
  logic [1:0]         winner_q, winner_d;

  logic               left_win_s;
  logic               right_win_s;
  logic [SCORE_W-1:0] left_inc_s;
  logic [SCORE_W-1:0] right_inc_s;

  // A simultaneous press or both ends lit (illegal light state) never wins.
  assign left_win_s  = leftEnd  & L & ~R & ~rightEnd;
  assign right_win_s = rightEnd & R & ~L & ~leftEnd;
  assign left_inc_s  = left_score_q  + SCORE_W'(1);
  assign right_inc_s = right_score_q + SCORE_W'(1);

  // State and datapath registers; reset aborts any hold or game-over at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_PLAY;
      hold_cnt_q    <= '0;
      left_score_q  <= '0;
      right_score_q <= '0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      winner_q      <= winner_d;
    end
  end

  // Next state, score, winner and hold count; inputs only matter in PLAY.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    winner_d      = winner_q;
    case (state_q)
      ST_PLAY: begin
        if (left_win_s) begin
          left_score_d = left_inc_s;
          winner_d     = 2'b10;
          if (left_inc_s == MAX_S) begin
            state_d = ST_OVER;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end else if (right_win_s) begin
          right_score_d = right_inc_s;
          winner_d      = 2'b01;
          if (right_inc_s == MAX_S) begin
            state_d = ST_OVER;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_RESTART;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      ST_RESTART: state_d = ST_PLAY;
      ST_OVER:    state_d = ST_OVER;
      default:    state_d = ST_PLAY;
    endcase
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    playAgain  = (state_q == ST_RESTART);
    gameOver   = (state_q == ST_OVER);
    leftScore  = left_score_q;
    rightScore = right_score_q;
    winner     = winner_q;
  end

endmodule

// File: tb/tb_tug_referee.sv
// Directed self-checking bench for tug_referee (MAX_SCORE=7, HOLD_CYCLES=4).
module tb_tug_referee;

  logic       clk;
  logic       reset;
  logic       L, R, leftEnd, rightEnd;
  logic       playAgain, gameOver;
  logic [2:0] leftScore, rightScore;
  logic [1:0] winner;
  logic [9:0] outs_s;

  int n_total = 0;
  int n_pass  = 0;

  tug_referee #(.SCORE_W(3), .MAX_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .leftEnd(leftEnd), .rightEnd(rightEnd),
    .playAgain(playAgain), .leftScore(leftScore), .rightScore(rightScore),
    .winner(winner), .gameOver(gameOver)
  );

  // {playAgain, gameOver, winner, leftScore, rightScore}
  assign outs_s = {playAgain, gameOver, winner, leftScore, rightScore};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; L = 1'b0; R = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;

    // 1. reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      L = 1'($urandom_range(0, 1)); R = 1'($urandom_range(0, 1));
      leftEnd = 1'($urandom_range(0, 1)); rightEnd = 1'($urandom_range(0, 1));
      step();
      chk("reset_hold", 16'(outs_s), 16'd0);
    end
    L = 1'b0; R = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", 16'(outs_s), 16'd0);
    end

    // 2. left win, then presses during hold are ignored
    leftEnd = 1'b1; L = 1'b1;
    step();                                           // edge E
    L = 1'b0;
    chk("lwin_E", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));
    L = 1'b1; step(); L = 1'b0;                       // E+1
    chk("hold_E1", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));
    step();                                           // E+2
    chk("hold_E2_pa", 16'(playAgain), 16'd0);
    L = 1'b1; step(); L = 1'b0;                       // E+3
    chk("hold_E3", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));
    L = 1'b1; step(); L = 1'b0;                       // E+4, press lands in RESTART
    chk("restart_E4", 16'(outs_s), 16'({1'b1, 1'b0, 2'b10, 3'd1, 3'd0}));
    step();                                           // E+5
    chk("play_E5", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));

    // 3. simultaneous press and illegal both-ends state: no win
    L = 1'b1; R = 1'b1; step(); L = 1'b0; R = 1'b0;
    chk("lr_both", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));
    rightEnd = 1'b1; L = 1'b1; step(); L = 1'b0;
    chk("ends_both", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));
    rightEnd = 1'b1; leftEnd = 1'b1; R = 1'b1; step(); R = 1'b0;
    chk("ends_both_r", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));
    leftEnd = 1'b0; rightEnd = 1'b0;
    begin
      logic seen_pa;
      seen_pa = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        seen_pa = seen_pa | playAgain;
      end
      chk("no_pa_after_nowin", 16'(seen_pa), 16'd0);
    end

    // 4. seven right wins end the game
    for (int i = 1; i <= 7; i++) begin
      rightEnd = 1'b1; R = 1'b1;
      step();
      rightEnd = 1'b0; R = 1'b0;
      chk("rwin_score", 16'(rightScore), 16'(i));
      chk("rwin_winner", 16'(winner), 16'd1);
      if (i < 7) begin
        chk("rwin_go", 16'(gameOver), 16'd0);
        step(); step(); step();
        chk("rwin_pa_lo", 16'(playAgain), 16'd0);
        step();
        chk("rwin_pa_hi", 16'(playAgain), 16'd1);
        step();
        chk("rwin_pa_end", 16'(playAgain), 16'd0);
      end else begin
        chk("final_E", 16'(outs_s), 16'({1'b0, 1'b1, 2'b01, 3'd1, 3'd7}));
      end
    end
    begin
      logic seen_pa;
      seen_pa = 1'b0;
      for (int i = 0; i < 6; i++) begin
        leftEnd = i[0]; L = 1'b1; rightEnd = ~i[0]; R = ~i[0];
        if (i == 5) begin rightEnd = 1'b0; leftEnd = 1'b1; R = 1'b0; end
        step();
        seen_pa = seen_pa | playAgain;
      end
      L = 1'b0; R = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;
      chk("over_no_pa", 16'(seen_pa), 16'd0);
      chk("over_hold", 16'(outs_s), 16'({1'b0, 1'b1, 2'b01, 3'd1, 3'd7}));
    end
    #2 reset = 1'b0;
    #1 chk("over_reset", 16'(outs_s), 16'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_over_reset", 16'(outs_s), 16'd0);

    // 5. asynchronous reset mid-hold
    leftEnd = 1'b1; L = 1'b1;
    step();                                           // win edge
    leftEnd = 1'b0; L = 1'b0;
    chk("async_pre", 16'(outs_s), 16'({1'b0, 1'b0, 2'b10, 3'd1, 3'd0}));
    step();
    #3 reset = 1'b0;                                  // between edges
    #1 chk("async_clear", 16'(outs_s), 16'd0);
    #2 reset = 1'b1;
    begin
      logic seen_pa;
      seen_pa = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        seen_pa = seen_pa | playAgain;
      end
      chk("async_no_pa", 16'(seen_pa), 16'd0);
      chk("async_after", 16'(outs_s), 16'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
